ir_queue: RTL and testbench
===========================

Name: ir_queue

Overview:
- Parametrised successor to the single-register instruction register of the simple CPU.
- Holds a small FIFO of prefetched instruction words captured from the MBR, and presents the current instruction (with opcode/operand split) to the control unit.
- Adds a flush function for branches and overflow detection.
- Sits between the MBR and the control unit/decoder. Driven by the shared 16-bit control_signals bus.

Parameters:
- DATA_W, 8, instruction word width (mbr2ir and ir_data).
- OPC_W, 4, opcode field width; opcode = ir_data[DATA_W-1 -: OPC_W]. Must satisfy 1 <= OPC_W < DATA_W.
- DEPTH, 4, prefetch queue entries. Must be a power of two, >= 2.
- LOAD_BIT, 6, control_signals index for push (capture mbr2ir into the queue).
- ADV_BIT, 7, control_signals index for advance (move queue head into the IR).
- FLUSH_BIT, 8, control_signals index for flush (discard all queued words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- control_signals  in  16  control bus; only LOAD_BIT, ADV_BIT and FLUSH_BIT are used.
- mbr2ir  in  DATA_W  instruction word from the MBR.
- ir_data  out  DATA_W  current instruction register.
- ir_opcode  out  OPC_W  upper OPC_W bits of ir_data (combinational).
- ir_operand  out  DATA_W-OPC_W  lower bits of ir_data (combinational).
- ir_valid  out  1  ir_data holds an instruction not yet consumed.
- q_count  out  $clog2(DEPTH+1)  number of queued words.
- q_full  out  1  q_count == DEPTH.
- q_empty  out  1  q_count == 0.
- overflow  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: ir_data=0, ir_valid=0, q_count=0, q_empty=1, q_full=0, overflow=0, read/write pointers=0.
- Strobes: push=control_signals[LOAD_BIT], adv=control_signals[ADV_BIT], flush=control_signals[FLUSH_BIT]. All are sampled at posedge clk.
- Priority is flush > adv > push for pointer and count updates, with the combined cases below.
- flush:
  - Pointers and q_count are set to 0; queued words are discarded.
  - ir_data and ir_valid are unchanged, because the instruction currently executing is the branch itself.
  - adv in the same cycle is ignored.
  - push in the same cycle writes mbr2ir as the sole entry (q_count=1). This is the branch-target fetch.
- adv without flush:
  - Queue non-empty: ir_data<=head, ir_valid<=1, head popped.
  - Queue empty and push the same cycle: bypass, ir_data<=mbr2ir, ir_valid<=1; the queue stays empty.
  - Queue empty and no push: ir_valid<=0; ir_data holds its value.
- push without flush:
  - Enqueued when !q_full, or when q_full and a pop occurs the same cycle; the net q_count is then unchanged.
  - push while q_full and no pop: the word is dropped, overflow<=1, and the queue is unchanged.
  - overflow clears only on reset.
- Latency:
  - push to visible in ir_data: 1 cycle via bypass, otherwise 1 cycle after the adv that pops it.
  - adv to ir_data update: 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- q_full and q_empty are derived from q_count, registered in the same cycle as the count update.
- Reset asserted mid-operation immediately returns every output to its reset value. Queue storage contents need not be cleared.
- Control bits other than the three selected indices are ignored.

Decomposition:
- Shared package cpu_ctrl_pkg holds the control-bus width (16) and the named bit indices for IR load, advance and flush. These serve as the defaults for LOAD_BIT, ADV_BIT and FLUSH_BIT.
- One sub-module, ir_fifo_core: DEPTH x DATA_W storage, pointers, count, full/empty.
  - Ports: wr_en, rd_en, clr, wr_data, rd_data.
  - The ir_queue top level holds the strobe decode, bypass, IR register, valid and overflow logic.

Test Plan:
- Reset, then push 0xA1, 0xB2, 0xC3 on three cycles, then adv x3 -> ir_data 0xA1, 0xB2, 0xC3 on successive cycles. ir_opcode 0xA, 0xB, 0xC. ir_valid=1. q_count 3->2->1->0.
- Empty queue, push=adv=1 with mbr2ir=0x5E -> next cycle ir_data=0x5E, ir_valid=1, q_count=0, q_empty=1.
- Push 5 words 0x11..0x15 with no adv (DEPTH=4) -> q_full=1 after the 4th. 5th is dropped, overflow=1. Four advs yield 0x11..0x14.
- Full queue, push=adv=1 with mbr2ir=0x77 -> head popped into ir_data, 0x77 enqueued, q_count stays 4, overflow stays 0.
- Queue holding 3 words, ir_data=0x42: assert flush+push (mbr2ir=0x90)+adv -> q_count=1, ir_data stays 0x42. Next adv gives ir_data=0x90.
- Queue holding 2 words, assert rst_n low mid-cycle -> all outputs go to reset values immediately. After release, adv with no push keeps ir_valid=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 16-bit CPU control bus: bus width and the
// bit positions that drive the instruction-register queue.
package cpu_ctrl_pkg;

    localparam int CTRL_W       = 16;

    // Instruction-register strobes on the control bus.
    localparam int IR_LOAD_BIT  = 6;   // capture mbr2ir into the prefetch queue
    localparam int IR_ADV_BIT   = 7;   // move queue head into the IR
    localparam int IR_FLUSH_BIT = 8;   // discard prefetched words (branch taken)

    typedef logic [CTRL_W-1:0] ctrl_bus_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ir_fifo_core.sv
// Prefetch storage for the instruction queue: DEPTH x DATA_W array with
// wrapping read/write pointers and a registered occupancy count.
// The caller guarantees legal strobes (no write when full without a read,
// no read when empty). clr restarts the queue; a write in the same cycle
// lands as the only entry.
module ir_fifo_core
    import cpu_ctrl_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [PTR_W-1:0]  wr_addr;
    logic [CNT_W-1:0]  count_next;

    // Next pointer/count values; clr overrides any read.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        wr_addr     = wr_ptr;
        if (clr) begin
            rd_ptr_next = '0;
            wr_addr     = '0;
            wr_ptr_next = wr_en ? PTR_W'(1) : '0;
            count_next  = wr_en ? CNT_W'(1) : '0;
        end else begin
            if (wr_en) wr_ptr_next = wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr_next = rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointer and count registers; full/empty follow the new count directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            full   <= (count_next == CNT_W'(DEPTH));
            empty  <= (count_next == '0);
        end
    end

    // Storage is not reset; stale words are never visible through count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register with a small prefetch queue. Words from the MBR are
// queued on LOAD, the head moves into the IR on ADV, and FLUSH drops the
// prefetched words on a taken branch while the IR (the branch itself) holds.
// An ADV on an empty queue with a simultaneous LOAD bypasses the queue.
// A LOAD into a full queue with no pop is dropped and sets a sticky overflow.
// DEPTH must be a power of two >= 2 and OPC_W must lie in 1..DATA_W-1.
module ir_queue
    import cpu_ctrl_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int OPC_W     = 4,
    parameter  int DEPTH     = 4,
    parameter  int LOAD_BIT  = IR_LOAD_BIT,
    parameter  int ADV_BIT   = IR_ADV_BIT,
    parameter  int FLUSH_BIT = IR_FLUSH_BIT,
    localparam int CNT_W     = count_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CTRL_W-1:0]       control_signals,
    input  logic [DATA_W-1:0]       mbr2ir,
    output logic [DATA_W-1:0]       ir_data,
    output logic [OPC_W-1:0]        ir_opcode,
    output logic [DATA_W-OPC_W-1:0] ir_operand,
    output logic                    ir_valid,
    output logic [CNT_W-1:0]        q_count,
    output logic                    q_full,
    output logic                    q_empty,
    output logic                    overflow
);

    logic              push;
    logic              adv;
    logic              flush;
    logic              pop;
    logic              bypass;
    logic              wr_en;
    logic              ovf_set;
    logic [DATA_W-1:0] head;
    logic              unused_ctrl;

    assign push  = control_signals[LOAD_BIT];
    assign adv   = control_signals[ADV_BIT];
    assign flush = control_signals[FLUSH_BIT];

    // Only three bus bits matter here; the rest belong to other blocks.
    assign unused_ctrl = ^control_signals;

    // Strobe decode: flush beats adv beats push; a push on a full queue is
    // still accepted when the head leaves in the same cycle.
    always_comb begin
        pop     = 1'b0;
        bypass  = 1'b0;
        wr_en   = 1'b0;
        ovf_set = 1'b0;
        if (flush) begin
            wr_en = push;
        end else begin
            pop    = adv && !q_empty;
            bypass = adv && q_empty && push;
            if (push && !bypass) begin
                if (!q_full || pop) wr_en   = 1'b1;
                else                ovf_set = 1'b1;
            end
        end
    end

    ir_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .rd_en   (pop),
        .clr     (flush),
        .wr_data (mbr2ir),
        .rd_data (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // IR register: load from the queue head or the bypass path on adv;
    // an adv with nothing available marks the IR consumed but keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_data  <= '0;
            ir_valid <= 1'b0;
        end else if (!flush && adv) begin
            if (pop) begin
                ir_data  <= head;
                ir_valid <= 1'b1;
            end else if (bypass) begin
                ir_data  <= mbr2ir;
                ir_valid <= 1'b1;
            end else begin
                ir_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
    end

    assign ir_opcode  = ir_data[DATA_W-1 -: OPC_W];
    assign ir_operand = ir_data[DATA_W-OPC_W-1:0];

endmodule

// File: tb/tb_ir_queue.sv
// Directed + random bench for ir_queue with a queue-based reference model
// and a scoreboard of expected IR loads.
module tb_ir_queue;
    import cpu_ctrl_pkg::*;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [CTRL_W-1:0]       control_signals;
    logic [DATA_W-1:0]       mbr2ir;
    logic [DATA_W-1:0]       ir_data;
    logic [OPC_W-1:0]        ir_opcode;
    logic [DATA_W-OPC_W-1:0] ir_operand;
    logic                    ir_valid;
    logic [CNT_W-1:0]        q_count;
    logic                    q_full;
    logic                    q_empty;
    logic                    overflow;

    int vectors = 0;
    int errors  = 0;

    // reference model
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] m_ir    = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf   = 1'b0;

    ir_queue #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .control_signals (control_signals),
        .mbr2ir          (mbr2ir),
        .ir_data         (ir_data),
        .ir_opcode       (ir_opcode),
        .ir_operand      (ir_operand),
        .ir_valid        (ir_valid),
        .q_count         (q_count),
        .q_full          (q_full),
        .q_empty         (q_empty),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_ir    = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":ir_data"},  32'(ir_data),  32'h0);
        chk({tag, ":ir_valid"}, 32'(ir_valid), 32'h0);
        chk({tag, ":q_count"},  32'(q_count),  32'h0);
        chk({tag, ":q_empty"},  32'(q_empty),  32'h1);
        chk({tag, ":q_full"},   32'(q_full),   32'h0);
        chk({tag, ":overflow"}, 32'(overflow), 32'h0);
    endtask

    task automatic check_state(input string tag);
        if (sb.size() > 0) chk({tag, ":ir_data"}, 32'(ir_data), 32'(sb.pop_front()));
        chk({tag, ":ir_opcode"},  32'(ir_opcode),  32'(m_ir[DATA_W-1 -: OPC_W]));
        chk({tag, ":ir_operand"}, 32'(ir_operand), 32'(m_ir[DATA_W-OPC_W-1:0]));
        chk({tag, ":ir_valid"},   32'(ir_valid),   32'(m_valid));
        chk({tag, ":q_count"},    32'(q_count),    32'(mq.size()));
        chk({tag, ":q_full"},     32'(q_full),     32'(mq.size() == DEPTH));
        chk({tag, ":q_empty"},    32'(q_empty),    32'(mq.size() == 0));
        chk({tag, ":overflow"},   32'(overflow),   32'(m_ovf));
    endtask

    // Drive one cycle of strobes (unused bus bits randomised), update the
    // model, then sample 1 ns after the edge.
    task automatic step(input string tag, input bit p, input bit a, input bit f,
                        input logic [DATA_W-1:0] d);
        logic [CTRL_W-1:0] cs;
        bit byp;
        cs = CTRL_W'($urandom);
        cs[IR_LOAD_BIT]  = p;
        cs[IR_ADV_BIT]   = a;
        cs[IR_FLUSH_BIT] = f;
        control_signals  = cs;
        mbr2ir           = d;
        byp = 1'b0;
        if (f) begin
            mq.delete();
            if (p) mq.push_back(d);
        end else begin
            if (a) begin
                if (mq.size() > 0) begin
                    m_ir    = mq.pop_front();
                    m_valid = 1'b1;
                    sb.push_back(m_ir);
                end else if (p) begin
                    byp     = 1'b1;
                    m_ir    = d;
                    m_valid = 1'b1;
                    sb.push_back(d);
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (p && !byp) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else                   m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    // Assert reset between edges and check outputs before any clock arrives.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        control_signals = '0;
        mbr2ir          = '0;
        repeat (2) @(posedge clk);
        #1 check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // basic push then advance
        step("push_a1", 1, 0, 0, 8'hA1);
        step("push_b2", 1, 0, 0, 8'hB2);
        step("push_c3", 1, 0, 0, 8'hC3);
        chk("cnt3", 32'(q_count), 32'd3);
        step("adv1", 0, 1, 0, 8'h00);
        chk("adv1_opc", 32'(ir_opcode), 32'hA);
        chk("adv1_cnt", 32'(q_count), 32'd2);
        step("adv2", 0, 1, 0, 8'h00);
        chk("adv2_opc", 32'(ir_opcode), 32'hB);
        step("adv3", 0, 1, 0, 8'h00);
        chk("adv3_opc", 32'(ir_opcode), 32'hC);
        chk("adv3_valid", 32'(ir_valid), 32'h1);
        chk("adv3_empty", 32'(q_empty), 32'h1);

        // bypass on empty queue
        step("bypass", 1, 1, 0, 8'h5E);
        chk("bypass_ir", 32'(ir_data), 32'h5E);
        chk("bypass_cnt", 32'(q_count), 32'd0);

        // fill and overflow
        for (int i = 0; i < 5; i++) begin
            step("fill", 1, 0, 0, 8'(8'h11 + i));
            if (i == 3) chk("full_after4", 32'(q_full), 32'h1);
            if (i == 3) chk("no_ovf_at4", 32'(overflow), 32'h0);
        end
        chk("ovf_after5", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 0, 1, 0, 8'h00);
            chk("drain_ir", 32'(ir_data), 32'(8'h11 + i));
        end

        // full queue with simultaneous push and pop
        mid_reset("reset2");
        for (int i = 0; i < 4; i++) step("fill2", 1, 0, 0, 8'(8'h21 + i));
        step("full_pushpop", 1, 1, 0, 8'h77);
        chk("fpp_ir", 32'(ir_data), 32'h21);
        chk("fpp_cnt", 32'(q_count), 32'd4);
        chk("fpp_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step("drain2", 0, 1, 0, 8'h00);
        chk("drain2_last", 32'(ir_data), 32'h77);

        // flush with branch-target fetch
        step("push42", 1, 0, 0, 8'h42);
        step("adv42", 0, 1, 0, 8'h00);
        step("pre1", 1, 0, 0, 8'h31);
        step("pre2", 1, 0, 0, 8'h32);
        step("pre3", 1, 0, 0, 8'h33);
        step("flush", 1, 1, 1, 8'h90);
        chk("flush_cnt", 32'(q_count), 32'd1);
        chk("flush_ir", 32'(ir_data), 32'h42);
        step("after_flush", 0, 1, 0, 8'h00);
        chk("target_ir", 32'(ir_data), 32'h90);

        // reset mid-operation
        step("pre_rst1", 1, 0, 0, 8'h61);
        step("pre_rst2", 1, 0, 0, 8'h62);
        mid_reset("mid_reset");
        step("adv_after_rst", 0, 1, 0, 8'h00);
        chk("valid_after_rst", 32'(ir_valid), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
